rtc_serial_master: RTL and testbench

- Initiator side of the Mac 3-wire RTC/PRAM serial link (_cs, ck, dat). It is the counterpart to the existing rtc responder.
- Runs complete one-byte-command transactions (command + one data byte, read or write) on request from a front-end agent. Typical agents are a PRAM save/restore engine or a debug port.
- Its outputs are muxed onto the RTC pins in place of VIA port B bits 2..0 while the agent owns the bus.

---
 rtl/rtc_serial_master.sv | 212 +++++++++++++++++++++
 tb/tb_rtc_serial_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_serial_master.sv
// rtc_serial_master: initiator for the 3-wire RTC/PRAM link, one command byte plus one data byte per request.
// Latency: 34 ticks (34*CLK_DIV clk8_en_p pulses) from accept to the one-cycle done pulse.
// Backpressure: none; req is honoured only in IDLE, abort returns to IDLE on the next clk32 edge.
module rtc_serial_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk32,
  input  logic       _systemReset,
  input  logic       clk8_en_p,
  input  logic       req,
  input  logic       abort,
  input  logic [7:0] cmd,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rtc_cs_n,
  output logic       rtc_ck,
  output logic       rtc_dat_o,
  output logic       rtc_dat_oe,
  input  logic       rtc_dat_i
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_CMD_LO = 3'd2;
  localparam logic [2:0] S_CMD_HI = 3'd3;
  localparam logic [2:0] S_DAT_LO = 3'd4;
  localparam logic [2:0] S_DAT_HI = 3'd5;
  localparam logic [2:0] S_HOLD   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rdata_q, rdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       cs_n_q, cs_n_d;
  logic       ck_q, ck_d;
  logic       dat_o_q, dat_o_d;
  logic       dat_oe_q, dat_oe_d;
  logic       tick;
  logic       is_rd;

  assign tick  = clk8_en_p && (div_q == DIV_MAX);
  assign is_rd = cmd_q[7];

  // Next-state, divider and pin values; every pin is computed here and registered below.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    cmd_d    = cmd_q;
    wdata_d  = wdata_q;
    shift_d  = shift_q;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cs_n_d   = cs_n_q;
    ck_d     = ck_q;
    dat_o_d  = dat_o_q;
    dat_oe_d = dat_oe_q;

    // Divider only runs while a transaction is in flight.
    if (state_q == S_IDLE) begin
      div_d = 8'd0;
    end else if (clk8_en_p) begin
      div_d = tick ? 8'd0 : div_q + 8'd1;
    end else begin
      div_d = div_q;
    end

    case (state_q)
      S_IDLE: begin
        if (req) begin
          cmd_d   = cmd;
          wdata_d = wdata;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          ck_d    = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tick) begin
          bitcnt_d = 3'd7;
          ck_d     = 1'b0;
          dat_oe_d = 1'b1;
          dat_o_d  = cmd_q[7];
          state_d  = S_CMD_LO;
        end
      end
      S_CMD_LO: begin
        if (tick) begin
          ck_d    = 1'b1;
          state_d = S_CMD_HI;
        end
      end
      S_CMD_HI: begin
        if (tick) begin
          ck_d = 1'b0;
          if (bitcnt_q != 3'd0) begin
            bitcnt_d = bitcnt_q - 3'd1;
            dat_oe_d = 1'b1;
            dat_o_d  = cmd_q[bitcnt_q - 3'd1];
            state_d  = S_CMD_LO;
          end else begin
            // Reads release dat from the very first data-bit low phase.
            bitcnt_d = 3'd7;
            dat_oe_d = !is_rd;
            dat_o_d  = is_rd ? dat_o_q : wdata_q[7];
            state_d  = S_DAT_LO;
          end
        end
      end
      S_DAT_LO: begin
        if (tick) begin
          // Read bit is captured at the end of the low phase, as ck rises.
          if (is_rd) shift_d[bitcnt_q] = rtc_dat_i;
          ck_d    = 1'b1;
          state_d = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        if (tick) begin
          if (bitcnt_q != 3'd0) begin
            bitcnt_d = bitcnt_q - 3'd1;
            ck_d     = 1'b0;
            if (!is_rd) dat_o_d = wdata_q[bitcnt_q - 3'd1];
            state_d  = S_DAT_LO;
          end else begin
            dat_oe_d = 1'b0;
            dat_o_d  = 1'b1;
            state_d  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (is_rd) rdata_d = shift_q;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over any progress except a req taken in IDLE; the done pulse in DONE is already out.
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      div_d    = 8'd0;
      cs_n_d   = 1'b1;
      ck_d     = 1'b1;
      dat_oe_d = 1'b0;
      dat_o_d  = 1'b1;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      rdata_d  = rdata_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      state_q  <= S_IDLE;
      div_q    <= 8'd0;
      bitcnt_q <= 3'd0;
      cmd_q    <= 8'h00;
      wdata_q  <= 8'h00;
      shift_q  <= 8'h00;
      rdata_q  <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      ck_q     <= 1'b1;
      dat_o_q  <= 1'b1;
      dat_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bitcnt_q <= bitcnt_d;
      cmd_q    <= cmd_d;
      wdata_q  <= wdata_d;
      shift_q  <= shift_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cs_n_q   <= cs_n_d;
      ck_q     <= ck_d;
      dat_o_q  <= dat_o_d;
      dat_oe_q <= dat_oe_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign rtc_cs_n   = cs_n_q;
  assign rtc_ck     = ck_q;
  assign rtc_dat_o  = dat_o_q;
  assign rtc_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_rtc_serial_master.sv
// Bench for rtc_serial_master: RTC responder model, scoreboard of expected transaction results,
// pin-timing monitor (phase lengths, cs_n low time, done latency), plus directed abort/reset cases.
module tb_rtc_serial_master;

  localparam int DIV = 4;

  logic       clk32 = 1'b0;
  logic       _systemReset;
  logic       clk8_en_p;
  logic       req, abort;
  logic [7:0] cmd, wdata;
  logic       busy, done;
  logic [7:0] rdata;
  logic       rtc_cs_n, rtc_ck, rtc_dat_o, rtc_dat_oe, rtc_dat_i;
  logic       en_gate;

  int errors = 0;
  int checks = 0;

  rtc_serial_master #(.CLK_DIV(DIV)) dut (
    .clk32       (clk32),
    ._systemReset(_systemReset),
    .clk8_en_p   (clk8_en_p),
    .req         (req),
    .abort       (abort),
    .cmd         (cmd),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .rtc_cs_n    (rtc_cs_n),
    .rtc_ck      (rtc_ck),
    .rtc_dat_o   (rtc_dat_o),
    .rtc_dat_oe  (rtc_dat_oe),
    .rtc_dat_i   (rtc_dat_i)
  );

  always #5 clk32 = ~clk32;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: PRAM contents as seen by the agent, and the rdata value the agent should hold.
  logic [7:0] ref_mem [128];
  logic [7:0] last_rdata;
  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  // RTC responder state.
  logic [7:0] rtc_mem [128];
  int         m_edges = 0;
  logic [7:0] m_cmd = 8'h00, m_dat = 8'h00, m_rbyte = 8'hFF;
  logic       m_oe_bad = 1'b0, m_dat_bad = 1'b0, m_busy_bad = 1'b0;
  int         f_edges = 0;
  logic [7:0] f_cmd = 8'h00, f_dat = 8'h00;
  logic       f_oe_bad = 1'b0, f_dat_bad = 1'b0, f_busy_bad = 1'b0;
  logic       p_cs = 1'b1, p_ck = 1'b1, p_dat = 1'b1, p_oe = 1'b0;
  int         ph_cnt = 0, cs_cnt = 0, pulse_cnt = 0, acc_mark = 0;
  logic       rd_phase;

  assign rtc_dat_i = (m_cmd[7] && m_edges >= 8 && m_edges < 16) ? m_rbyte[3'(15 - m_edges)] : 1'b1;

  // Responder + monitor, sampled on the falling clk32 edge, away from DUT updates.
  always @(negedge clk32) begin
    if (!rtc_cs_n && p_cs) begin
      m_edges = 0; m_cmd = 8'h00; m_dat = 8'h00;
      m_oe_bad = 1'b0; m_dat_bad = 1'b0; m_busy_bad = 1'b0;
      ph_cnt = 0; cs_cnt = 0;
    end
    if (!rtc_cs_n) begin
      if (!busy) m_busy_bad = 1'b1;
      if (p_cs == 1'b0 && rtc_ck != p_ck) begin
        chk("ck_phase_len", ph_cnt, DIV);
        ph_cnt = 0;
      end
      if (rtc_ck && !p_ck) begin
        rd_phase = m_cmd[7] && (m_edges >= 8);
        if (rtc_dat_oe == rd_phase) m_oe_bad = 1'b1;
        if (m_edges < 8) m_cmd = {m_cmd[6:0], rtc_dat_o};
        else if (m_edges < 16) m_dat = {m_dat[6:0], rtc_dat_o};
        m_edges++;
        if (m_edges == 8) m_rbyte = rtc_mem[m_cmd[6:0]];
      end
      if (m_cmd[7] && m_edges >= 8 && (m_edges > 8 || !rtc_ck) && rtc_dat_oe) m_oe_bad = 1'b1;
      if (rtc_ck && p_ck && rtc_dat_oe && p_oe && rtc_dat_o != p_dat) m_dat_bad = 1'b1;
    end
    if (rtc_cs_n && !p_cs) begin
      f_edges = m_edges; f_cmd = m_cmd; f_dat = m_dat;
      f_oe_bad = m_oe_bad; f_dat_bad = m_dat_bad; f_busy_bad = m_busy_bad;
      if (m_edges == 16) begin
        chk("cs_low_len", cs_cnt, 34 * DIV);
        if (!m_cmd[7]) rtc_mem[m_cmd[6:0]] = m_dat;
      end
    end

    if (done) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending transaction");
      end else begin
        mon_e = sb_q.pop_front();
        chk("rdata", 32'(rdata), 32'(mon_e.rdata));
        chk("done_latency", pulse_cnt - acc_mark, 34 * DIV);
        chk("ck_rises", f_edges, 16);
        chk("cmd_bits", 32'(f_cmd), 32'(mon_e.cmd));
        if (!mon_e.cmd[7]) chk("wdata_bits", 32'(f_dat), 32'(mon_e.wdata));
        chk("oe_pattern", 32'(f_oe_bad), 32'(0));
        chk("dat_stable_ck_hi", 32'(f_dat_bad), 32'(0));
        chk("busy_during_cs", 32'(f_busy_bad), 32'(0));
        chk("busy_at_done", 32'(busy), 32'(0));
      end
    end

    if (clk8_en_p) begin
      pulse_cnt++; ph_cnt++; cs_cnt++;
    end
    if (req && !busy && !done && _systemReset) acc_mark = pulse_cnt;

    p_cs = rtc_cs_n; p_ck = rtc_ck; p_dat = rtc_dat_o; p_oe = rtc_dat_oe;
  end

  // Random 8 MHz enable, optionally forced off.
  initial begin
    clk8_en_p = 1'b0;
    forever begin
      @(posedge clk32); #1;
      clk8_en_p = en_gate ? 1'b0 : ($urandom_range(0, 2) == 0);
    end
  end

  task automatic txn(input logic [7:0] c, input logic [7:0] w, input bit track, input bit with_abort);
    exp_t e;
    @(posedge clk32); #1;
    req = 1'b1; abort = with_abort; cmd = c; wdata = w;
    if (track) begin
      if (c[7]) last_rdata = ref_mem[c[6:0]];
      else      ref_mem[c[6:0]] = w;
      e.cmd = c; e.wdata = w; e.rdata = last_rdata;
      sb_q.push_back(e);
    end
    @(posedge clk32); #1;
    req = 1'b0; abort = 1'b0; cmd = 8'($urandom); wdata = 8'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk32);
    while ((busy || done) && k < 20000) begin
      @(negedge clk32);
      k++;
    end
    if (k >= 20000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=%0b expected 0 within 20000 cycles", busy);
    end
  endtask

  // Returns on the falling clk32 edge once n ck rises were seen (and ck is low, if asked).
  task automatic wait_rises(input int n, input bit want_low);
    int cnt = 0;
    int k = 0;
    logic pk;
    pk = rtc_ck;
    while (k < 5000 && !(cnt >= n && (!want_low || !rtc_ck))) begin
      @(negedge clk32);
      if (!rtc_cs_n && rtc_ck && !pk) cnt++;
      pk = rtc_ck;
      k++;
    end
    if (k >= 5000) begin
      checks++; errors++;
      $display("FAIL rise_timeout: got %0d rises expected %0d", cnt, n);
    end
  endtask

  logic [5:0] snap;
  logic       chg;
  logic [7:0] rc;

  initial begin
    _systemReset = 1'b1; req = 1'b0; abort = 1'b0; cmd = 8'h00; wdata = 8'h00; en_gate = 1'b0;
    for (int i = 0; i < 128; i++) begin
      rc = 8'($urandom);
      rtc_mem[i] = rc; ref_mem[i] = rc;
    end
    rtc_mem[7'h38] = 8'h5A; ref_mem[7'h38] = 8'h5A;
    last_rdata = 8'h00;
    #1 _systemReset = 1'b0;
    repeat (3) @(negedge clk32);
    chk("rst_cs_n", 32'(rtc_cs_n), 32'(1));
    chk("rst_ck", 32'(rtc_ck), 32'(1));
    chk("rst_dat_o", 32'(rtc_dat_o), 32'(1));
    chk("rst_dat_oe", 32'(rtc_dat_oe), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(8'h00));
    @(posedge clk32); #1 _systemReset = 1'b1;

    // Write then read back, then a preloaded read.
    txn(8'h35, 8'hA5, 1'b1, 1'b0); wait_idle();
    txn(8'hB5, 8'h00, 1'b1, 1'b0); wait_idle();
    txn(8'hB8, 8'h3C, 1'b1, 1'b0); wait_idle();

    // Enable stalled mid-bit: nothing on the pins may move.
    txn(8'h12, 8'hC3, 1'b1, 1'b0);
    wait_rises(3, 1'b1);
    en_gate = 1'b1;
    repeat (2) @(negedge clk32);
    snap = {rtc_cs_n, rtc_ck, rtc_dat_o, rtc_dat_oe, busy, done};
    chg = 1'b0;
    repeat (100) begin
      @(negedge clk32);
      if ({rtc_cs_n, rtc_ck, rtc_dat_o, rtc_dat_oe, busy, done} != snap) chg = 1'b1;
    end
    chk("stall_no_change", 32'(chg), 32'(0));
    chk("stall_cs_low", 32'(rtc_cs_n), 32'(0));
    en_gate = 1'b0;
    wait_idle();

    // Abort in the third command-bit high phase.
    txn(8'h21, 8'h77, 1'b0, 1'b0);
    wait_rises(3, 1'b0);
    @(posedge clk32); #1 abort = 1'b1;
    @(posedge clk32); #1 abort = 1'b0;
    @(negedge clk32);
    chk("abort_cs_n", 32'(rtc_cs_n), 32'(1));
    chk("abort_ck", 32'(rtc_ck), 32'(1));
    chk("abort_oe", 32'(rtc_dat_oe), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_rdata", 32'(rdata), 32'(8'h5A));
    repeat (20) @(negedge clk32);
    txn(8'h21, 8'h77, 1'b1, 1'b0); wait_idle();

    // Asynchronous reset in a read data low phase.
    txn(8'hA1, 8'h00, 1'b1, 1'b0);
    wait_rises(9, 1'b1);
    #3 _systemReset = 1'b0;
    #1;
    chk("arst_cs_n", 32'(rtc_cs_n), 32'(1));
    chk("arst_ck", 32'(rtc_ck), 32'(1));
    chk("arst_dat_o", 32'(rtc_dat_o), 32'(1));
    chk("arst_oe", 32'(rtc_dat_oe), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_rdata", 32'(rdata), 32'(8'h00));
    sb_q.delete();
    last_rdata = 8'h00;
    @(posedge clk32); #1 _systemReset = 1'b1;
    chg = 1'b0;
    repeat (20) begin
      @(negedge clk32);
      if (!rtc_ck || !rtc_cs_n || busy) chg = 1'b1;
    end
    chk("post_rst_quiet", 32'(chg), 32'(0));

    // Second req while busy is ignored.
    txn(8'h05, 8'h96, 1'b1, 1'b0);
    repeat (60) @(negedge clk32);
    @(posedge clk32); #1 req = 1'b1; cmd = 8'h86; wdata = 8'h11;
    @(posedge clk32); #1 req = 1'b0;
    wait_idle();
    chg = 1'b0;
    repeat (30) begin
      @(negedge clk32);
      if (busy) chg = 1'b1;
    end
    chk("req_busy_ignored", 32'(chg), 32'(0));

    // req and abort together in IDLE: the transaction starts.
    txn(8'h85, 8'h00, 1'b1, 1'b1);
    @(negedge clk32);
    chk("req_abort_busy", 32'(busy), 32'(1));
    wait_idle();

    // Random mix on a small address window so reads hit earlier writes.
    for (int n = 0; n < 16; n++) begin
      rc = {1'($urandom_range(0, 1)), 4'b0000, 3'($urandom_range(0, 7))};
      txn(rc, 8'($urandom), 1'b1, 1'b0);
      wait_idle();
    end

    repeat (5) @(negedge clk32);
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
